// File: rtl/disk_seq_ctrl_if.sv
// disk_seq_ctrl_if
//   Bundles the sequencer's config, status, core-side and stream-side signals.
//   master : the sequencer (drives core_*, out_*, busy, seq_done)
//   slave  : the environment (drives cfg_*, core results, out_ready)
//   Signals:
//     cfg_start/cfg_k_first/cfg_count/cfg_base_sel0/1/cfg_abort  run control
//     busy, seq_done                                             run status
//     core_start/core_k/core_base_sel0/1, core_ready/done/x/y    core handshake
//     out_valid/out_ready/out_x/out_y/out_k/out_last             point stream
interface disk_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cfg_start;
  logic [31:0]      cfg_k_first;
  logic [CNT_W-1:0] cfg_count;
  logic [1:0]       cfg_base_sel0;
  logic [1:0]       cfg_base_sel1;
  logic             cfg_abort;
  logic             busy;
  logic             seq_done;
  logic             core_start;
  logic [31:0]      core_k;
  logic [1:0]       core_base_sel0;
  logic [1:0]       core_base_sel1;
  logic             core_ready;
  logic             core_done;
  logic [31:0]      core_x;
  logic [31:0]      core_y;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_x;
  logic [31:0]      out_y;
  logic [31:0]      out_k;
  logic             out_last;

  modport master (
    input  cfg_start, cfg_k_first, cfg_count, cfg_base_sel0, cfg_base_sel1, cfg_abort,
    output busy, seq_done,
    output core_start, core_k, core_base_sel0, core_base_sel1,
    input  core_ready, core_done, core_x, core_y,
    output out_valid, out_x, out_y, out_k, out_last,
    input  out_ready
  );

  modport slave (
    output cfg_start, cfg_k_first, cfg_count, cfg_base_sel0, cfg_base_sel1, cfg_abort,
    input  busy, seq_done,
    input  core_start, core_k, core_base_sel0, core_base_sel1,
    output core_ready, core_done, core_x, core_y,
    input  out_valid, out_x, out_y, out_k, out_last,
    output out_ready
  );
endinterface

// File: rtl/disk_seq_ctrl.sv
// disk_seq_ctrl
//   Runs a disk point-generator core over indices k_first .. k_first+count-1,
//   one operation in flight at a time, and streams the results through a
//   show-ahead FIFO as {x, y, k, last} beats.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     bus          disk_seq_ctrl_if.master (config, status, core, stream)
//     stall_cnt    (only with DISK_SEQ_STALL_CNT_EN) saturating count of
//                  cycles with out_valid && !out_ready, cleared on each
//                  accepted cfg_start
//   Optional feature macro: DISK_SEQ_STALL_CNT_EN
module disk_seq_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  disk_seq_ctrl_if.master   bus
`ifdef DISK_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] k;
    logic        last;
  } beat_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_ABORT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_k;
  logic [CNT_W-1:0] r_rem;
  logic [1:0]       r_bs0, r_bs1;
  logic             r_seq_done;

  beat_t            r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_occ;

  logic             w_start_acc, w_issue, w_push, w_pop, w_flush;
  logic             w_seq_done_nxt, w_empty, w_full, w_last;
  beat_t            w_head, w_push_beat;

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_last  = (r_rem == CNT_W'(1));

  // ---------------- FSM: next state / control ----------------
  always_comb begin
    w_state_nxt    = r_state;
    w_start_acc    = 1'b0;
    w_issue        = 1'b0;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    w_seq_done_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // start beats a coincident abort simply because abort is not looked at here
        if (bus.cfg_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (bus.cfg_count == '0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.cfg_abort) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus.core_ready && !w_full) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.cfg_abort) begin
          // If the result lands in the abort cycle itself there is nothing
          // left to wait for; drop it now instead of parking in ABORT forever.
          if (bus.core_done) begin
            w_flush     = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_ABORT;
          end
        end else if (bus.core_done) begin
          // Space was checked before issuing and only pops happen meanwhile,
          // so this push always fits.
          w_push      = 1'b1;
          w_state_nxt = w_last ? S_DRAIN : S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (bus.cfg_abort) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_empty) begin
          w_seq_done_nxt = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      S_ABORT: begin
        if (bus.core_done) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- state, run registers, FIFO pointers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_rem      <= '0;
      r_bs0      <= '0;
      r_bs1      <= '0;
      r_seq_done <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_seq_done <= w_seq_done_nxt;
      if (w_start_acc) begin
        r_k   <= bus.cfg_k_first;
        r_rem <= bus.cfg_count;
        r_bs0 <= bus.cfg_base_sel0;
        r_bs1 <= bus.cfg_base_sel1;
      end else if (w_push) begin
        r_k   <= r_k + 32'd1;           // wraps 0xFFFFFFFF -> 0
        r_rem <= r_rem - CNT_W'(1);
      end
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        r_occ <= r_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  assign w_push_beat = '{x: bus.core_x, y: bus.core_y, k: r_k, last: w_last};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_beat;
  end

  assign w_head = r_mem[r_rptr];

  // ---------------- outputs ----------------
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.seq_done       = r_seq_done;
  assign bus.core_start     = w_issue;
  assign bus.core_k         = r_k;
  assign bus.core_base_sel0 = r_bs0;
  assign bus.core_base_sel1 = r_bs1;
  assign bus.out_valid      = !w_empty;
  assign bus.out_x          = w_empty ? '0   : w_head.x;
  assign bus.out_y          = w_empty ? '0   : w_head.y;
  assign bus.out_k          = w_empty ? '0   : w_head.k;
  assign bus.out_last       = w_empty ? 1'b0 : w_head.last;

`ifdef DISK_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (!w_empty && !bus.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_disk_seq_ctrl.sv
module tb_disk_seq_ctrl;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disk_seq_ctrl_if #(.CNT_W(CNT_W)) bus();

`ifdef DISK_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  disk_seq_ctrl #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DISK_SEQ_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- mock core: 3-cycle latency, x=k, y=k+0x100 ----------------
  logic        m_busy = 1'b0;
  logic [1:0]  m_cnt  = 2'd0;
  logic [31:0] m_k    = 32'd0;
  assign bus.core_ready = !m_busy;
  always @(posedge clk) begin
    bus.core_done <= 1'b0;
    if (m_busy) begin
      m_cnt <= m_cnt - 2'd1;
      if (m_cnt == 2'd1) begin
        m_busy        <= 1'b0;
        bus.core_done <= 1'b1;
        bus.core_x    <= m_k;
        bus.core_y    <= m_k + 32'h100;
      end
    end else if (bus.core_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 2'd2;
      m_k    <= bus.core_k;
    end
  end

  // ---------------- monitor (samples on falling edge) ----------------
  int n_beats = 0, n_starts = 0, n_sd = 0, n_valid = 0, n_stall = 0;
  int hold_err = 0, bs_err = 0;
  logic [31:0] mk [512];
  logic [31:0] mx [512];
  logic [31:0] my [512];
  logic        ml [512];
  int          sd_beats [64];
  logic        p_stall = 1'b0, p_abort = 1'b0;
  logic [96:0] p_data = '0;
  logic [1:0]  exp_bs0 = 2'd0, exp_bs1 = 2'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.core_start) n_starts++;
      if (bus.seq_done) begin
        sd_beats[n_sd % 64] = n_beats;
        n_sd++;
      end
      if (bus.out_valid) n_valid++;
      if (p_stall && !p_abort &&
          (!bus.out_valid || {bus.out_x, bus.out_y, bus.out_k, bus.out_last} !== p_data))
        hold_err++;
      if (bus.busy && (bus.core_base_sel0 !== exp_bs0 || bus.core_base_sel1 !== exp_bs1))
        bs_err++;
      if (bus.out_valid && bus.out_ready && n_beats < 512) begin
        mk[n_beats] = bus.out_k;
        mx[n_beats] = bus.out_x;
        my[n_beats] = bus.out_y;
        ml[n_beats] = bus.out_last;
        n_beats++;
      end
      if (bus.out_valid && !bus.out_ready) n_stall++;
      p_stall = bus.out_valid && !bus.out_ready;
      p_abort = bus.cfg_abort;
      p_data  = {bus.out_x, bus.out_y, bus.out_k, bus.out_last};
    end else begin
      p_stall = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int total = 0, bad = 0;

  `define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s: got 0x%0h expected 0x%0h", tag, (obs), (exp)); end end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] kf, input logic [CNT_W-1:0] cnt,
                           input logic [1:0] b0, input logic [1:0] b1, input bit upd);
    step();
    bus.cfg_k_first   = kf;
    bus.cfg_count     = cnt;
    bus.cfg_base_sel0 = b0;
    bus.cfg_base_sel1 = b1;
    bus.cfg_start     = 1'b1;
    if (upd) begin
      exp_bs0 = b0;
      exp_bs1 = b1;
    end
    step();
    bus.cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int sd0, input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (n_sd != sd0) begin
        ok = 1'b1;
        break;
      end
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    end
    bus.out_ready = 1'b1;
    `CHK({tag, " seq_done seen"}, ok, 1'b1)
  endtask

  // Reference: run of cnt points starting at kf, k wrapping in 32 bits.
  task automatic check_run(input string tag, input int b0, input logic [31:0] kf, input int cnt);
    logic [31:0] ek;
    `CHK({tag, " beat count"}, n_beats - b0, cnt)
    for (int i = 0; i < cnt && (b0 + i) < n_beats; i++) begin
      ek = kf + 32'(i);
      `CHK($sformatf("%s k[%0d]", tag, i), mk[b0+i], ek)
      `CHK($sformatf("%s x[%0d]", tag, i), mx[b0+i], ek)
      `CHK($sformatf("%s y[%0d]", tag, i), my[b0+i], ek + 32'h100)
      `CHK($sformatf("%s last[%0d]", tag, i), ml[b0+i], (i == cnt - 1))
    end
  endtask

  initial begin
    int b, sd0, st0, v0, stl0, cnt;
    logic [31:0] kf;
    logic [1:0]  rb0, rb1;
    bit seen;

    bus.cfg_start = 1'b0;
    bus.cfg_abort = 1'b0;
    bus.cfg_k_first = '0;
    bus.cfg_count = '0;
    bus.cfg_base_sel0 = '0;
    bus.cfg_base_sel1 = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();

    // reset state
    @(negedge clk);
    `CHK("rst busy", bus.busy, 1'b0)
    `CHK("rst seq_done", bus.seq_done, 1'b0)
    `CHK("rst core_start", bus.core_start, 1'b0)
    `CHK("rst core_k", bus.core_k, 32'd0)
    `CHK("rst out_valid", bus.out_valid, 1'b0)
    `CHK("rst out_x", bus.out_x, 32'd0)
    `CHK("rst out_k", bus.out_k, 32'd0)
    `CHK("rst out_last", bus.out_last, 1'b0)
    `CHK("rst base_sel0", bus.core_base_sel0, 2'd0)
    step();
    rst_n = 1'b1;
    step();

    // single run
    b = n_beats; sd0 = n_sd; st0 = n_starts;
    start_run(32'd1, 16'd3, 2'b00, 2'b01, 1'b1);
    wait_done("single", sd0, 1'b0);
    repeat (5) step();
    check_run("single", b, 32'd1, 3);
    `CHK("single seq_done count", n_sd - sd0, 1)
    `CHK("single seq_done after beats", sd_beats[sd0 % 64], b + 3)
    `CHK("single core_start count", n_starts - st0, 3)
    `CHK("single base_sel", bs_err, 0)

    // backpressure
    bus.out_ready = 1'b0;
    b = n_beats; sd0 = n_sd; st0 = n_starts; stl0 = n_stall;
    start_run(32'h40, 16'd8, 2'b10, 2'b00, 1'b1);
    for (int i = 0; i < 100 && (n_starts - st0) < 4; i++) step();
    repeat (20) step();
    `CHK("bp no fifth start", n_starts - st0, 4)
    @(negedge clk);
    `CHK("bp head valid", bus.out_valid, 1'b1)
    `CHK("bp head k", bus.out_k, 32'h40)
    step();
`ifdef DISK_SEQ_STALL_CNT_EN
    `CHK("bp stall_cnt held", stall_cnt, 32'(n_stall - stl0))
`endif
    bus.out_ready = 1'b1;
    wait_done("bp", sd0, 1'b0);
    step();
    check_run("bp", b, 32'h40, 8);
`ifdef DISK_SEQ_STALL_CNT_EN
    `CHK("bp stall_cnt final", stall_cnt, 32'(n_stall - stl0))
`endif

    // k wrap
    b = n_beats; sd0 = n_sd;
    start_run(32'hFFFF_FFFF, 16'd2, 2'b01, 2'b10, 1'b1);
    wait_done("wrap", sd0, 1'b0);
    check_run("wrap", b, 32'hFFFF_FFFF, 2);

    // zero-length run
    b = n_beats; sd0 = n_sd; st0 = n_starts; v0 = n_valid;
    start_run(32'h1234, 16'd0, 2'b00, 2'b00, 1'b1);
    @(negedge clk);
    `CHK("zero busy c+1", bus.busy, 1'b1)
    `CHK("zero seq_done c+1", bus.seq_done, 1'b0)
    @(negedge clk);
    `CHK("zero seq_done c+2", bus.seq_done, 1'b1)
    `CHK("zero busy c+2", bus.busy, 1'b0)
    repeat (3) step();
    `CHK("zero core_start", n_starts - st0, 0)
    `CHK("zero out_valid", n_valid - v0, 0)
    `CHK("zero seq_done count", n_sd - sd0, 1)

    // abort during the second operation
    kf = $urandom;
    b = n_beats; sd0 = n_sd; st0 = n_starts;
    start_run(kf, 16'd5, 2'b10, 2'b01, 1'b1);
    for (int i = 0; i < 100 && (n_starts - st0) < 2; i++) step();
    bus.cfg_abort = 1'b1;
    step();
    bus.cfg_abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.core_done && bus.busy) seen = 1'b1;
      if (!bus.busy) break;
    end
    `CHK("abort busy held until core_done", seen, 1'b1)
    `CHK("abort busy low", bus.busy, 1'b0)
    `CHK("abort out_valid", bus.out_valid, 1'b0)
    repeat (3) step();
    `CHK("abort no seq_done", n_sd - sd0, 0)
    `CHK("abort starts", n_starts - st0, 2)
    `CHK("abort beats", n_beats - b, 1)
    `CHK("abort first k", mk[b], kf)
    b = n_beats; sd0 = n_sd;
    start_run(32'd10, 16'd1, 2'b00, 2'b10, 1'b1);
    wait_done("post-abort", sd0, 1'b0);
    check_run("post-abort", b, 32'd10, 1);

    // reset mid-run
    st0 = n_starts; sd0 = n_sd;
    start_run($urandom, 16'd4, 2'b01, 2'b01, 1'b1);
    for (int i = 0; i < 100 && (n_starts - st0) < 1; i++) step();
    rst_n = 1'b0;
    #1;
    `CHK("midrst busy", bus.busy, 1'b0)
    `CHK("midrst core_k", bus.core_k, 32'd0)
    `CHK("midrst core_start", bus.core_start, 1'b0)
    `CHK("midrst out_valid", bus.out_valid, 1'b0)
    `CHK("midrst base_sel1", bus.core_base_sel1, 2'd0)
    step(); step();
    rst_n = 1'b1;
    step();
    `CHK("midrst no seq_done", n_sd - sd0, 0)
    kf = $urandom;
    b = n_beats; sd0 = n_sd;
    start_run(kf, 16'd2, 2'b10, 2'b10, 1'b1);
    wait_done("after-rst", sd0, 1'b1);
    check_run("after-rst", b, kf, 2);

    // start while busy is ignored
    kf = $urandom;
    b = n_beats; sd0 = n_sd; st0 = n_starts;
    start_run(kf, 16'd6, 2'b01, 2'b00, 1'b1);
    repeat (3) step();
    start_run(kf + 32'd100, 16'd7, 2'b10, 2'b10, 1'b0);
    wait_done("ignored", sd0, 1'b1);
    repeat (3) step();
    check_run("ignored", b, kf, 6);
    `CHK("ignored starts", n_starts - st0, 6)
    `CHK("ignored seq_done count", n_sd - sd0, 1)

    // randomized runs with random backpressure
    for (int r = 0; r < 5; r++) begin
      kf  = $urandom;
      cnt = $urandom_range(1, 9);
      rb0 = 2'($urandom_range(0, 2));
      rb1 = 2'($urandom_range(0, 2));
      b = n_beats; sd0 = n_sd;
      start_run(kf, CNT_W'(cnt), rb0, rb1, 1'b1);
      wait_done($sformatf("rnd%0d", r), sd0, 1'b1);
      check_run($sformatf("rnd%0d", r), b, kf, cnt);
    end

    step();
    `CHK("base_sel stable", bs_err, 0)
    `CHK("stream hold under stall", hold_err, 0)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disk_seq_ctrl.md
Name: disk_seq_ctrl

Overview:
- Sequencer that drives one disk point-generator core (start/k/base_sel/ready/done interface) through a run of consecutive indices k_first .. k_first+count-1.
- Results are buffered in a small show-ahead FIFO and streamed out over a valid/ready interface tagged with k and a last flag.
- Sits between the software-visible config registers and the disk core, so consumers see a point stream instead of single-shot handshakes.

Parameters:
- FIFO_DEPTH, 4, output buffer entries (power of two, >=2).
- CNT_W, 16, width of the run-length count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  one-cycle pulse; latches cfg_* and begins a run.
- cfg_k_first  in  32  first index of the run.
- cfg_count  in  CNT_W  number of points in the run.
- cfg_base_sel0  in  2  base select, dimension 0 (00=2, 01=3, 10=7).
- cfg_base_sel1  in  2  base select, dimension 1.
- cfg_abort  in  1  one-cycle pulse; cancels the active run.
- busy  out  1  high whenever state != IDLE.
- seq_done  out  1  one-cycle pulse when a run completes and the FIFO has drained.
- core_start  out  1  one-cycle start pulse to the core.
- core_k  out  32  index to the core.
- core_base_sel0  out  2  to the core; constant for the whole run.
- core_base_sel1  out  2  to the core; constant for the whole run.
- core_ready  in  1  core idle.
- core_done  in  1  core result-valid pulse, one cycle wide.
- core_x  in  32  core result x.
- core_y  in  32  core result y.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_x  out  32  point x.
- out_y  out  32  point y.
- out_k  out  32  index of the point.
- out_last  out  1  marks the final point of the run.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, internal counters 0. An asynchronous reset mid-run discards everything; the core is not notified.
- States: IDLE, ISSUE, WAIT, DRAIN, ABORT.
- IDLE:
  - cfg_start=1 latches k_first, count and base_sels.
  - count!=0 goes to ISSUE.
  - count==0 goes to DRAIN; this yields seq_done two cycles after cfg_start and never pulses core_start.
- ISSUE:
  - When core_ready=1 and FIFO occupancy < FIFO_DEPTH, assert core_start for exactly one cycle with core_k = current k, then go to WAIT.
  - Otherwise hold; core_start stays 0.
- WAIT:
  - On core_done=1, push {core_x, core_y, k, last} into the FIFO in that same cycle. last is set when the remaining count equals 1.
  - Then increment k modulo 2^32 (0xFFFFFFFF wraps to 0) and decrement remaining.
  - Remaining==0 goes to DRAIN; otherwise ISSUE.
  - At most one core operation is in flight, so a push can never overflow the FIFO.
- DRAIN: when the FIFO is empty, pulse seq_done for one cycle and go to IDLE.
- Latency: cfg_start sampled at edge N gives the first core_start in cycle N+1 when the core is ready. A core_done in cycle M gives out_valid=1 from cycle M+1.
- Output stream:
  - out_* comes from the FIFO head.
  - Pop on out_valid && out_ready.
  - out_* must hold stable while out_valid && !out_ready.
  - Push and pop in the same cycle are both performed.
- cfg_start while busy=1 is ignored.
- cfg_abort:
  - In ISSUE or DRAIN: flush the FIFO and go to IDLE next cycle.
  - In WAIT: go to ABORT, wait for core_done, discard that result, flush the FIFO, then go to IDLE.
  - In IDLE: no effect.
  - seq_done is never pulsed for an aborted run.
  - cfg_abort and cfg_start in the same IDLE cycle: start wins.
- core_base_sel0/1 are driven from the latched registers and remain unchanged from IDLE exit to IDLE entry.

Optional Feature:
- Macro: DISK_SEQ_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt (32 bits), which increments each cycle out_valid && !out_ready.
  - It saturates at 0xFFFFFFFF, clears on reset and on each accepted cfg_start.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- All tests use a mock core with 3-cycle latency returning x=k, y=k+0x100.
- Single run: cfg_k_first=1, cfg_count=3, bases 00/01, out_ready=1.
  - Expect three beats (k,x,y) = (1,1,0x101), (2,2,0x102), (3,3,0x103); out_last only on k=3.
  - Expect seq_done exactly once, after the third beat.
  - Expect core_base_sel = 00/01 throughout.
- Backpressure: count=8, out_ready=0 until the FIFO holds 4 entries.
  - Expect no fifth core_start while full.
  - Release out_ready and expect all 8 points in order, none lost or duplicated.
  - With DISK_SEQ_STALL_CNT_EN, stall_cnt equals the number of held cycles.
- Wrap and zero: cfg_k_first=0xFFFFFFFF, count=2 gives out_k 0xFFFFFFFF then 0x00000000. A separate count=0 run gives a seq_done pulse, no core_start and no out_valid.
- Abort in WAIT: count=5, cfg_abort during the second op.
  - The pending core_done is consumed, the FIFO is flushed, and out_valid=0.
  - busy falls after core_done, with no seq_done.
  - A following run (k_first=10, count=1) yields k=10.
- Reset mid-run: deassert rst_n during WAIT.
  - All outputs go to 0 immediately.
  - After release, a new run of count=2 completes normally.
- Ignored start: pulse cfg_start with different k while busy; the output sequence is unchanged from the original run.
